fpga_bram_ctrl: RTL and testbench
=================================

Name: fpga_bram_ctrl

Overview:
Controller stage directly upstream of the FPGA BRAM model. Accepts one 256-bit cache-line read or write from the cache/arbiter side and serializes it onto the BRAM's multiplexed 64-bit address/data bus: one address beat, then four data beats. It collects read beats into a line, handshakes completion back upstream, and flags a stuck memory with a response timeout.

Parameters:
ADDR_WIDTH, 32, upstream byte-address width; the address beat zero-extends it to BUS_WIDTH.
BUS_WIDTH, 64, width of the multiplexed BRAM address/data bus.
BEATS, 4, data beats per line; line width is BEATS*BUS_WIDTH (256).
TIMEOUT_CYCLES, 1023, idle cycles allowed without resp_i while a response is awaited.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset).
ufp_read  input  1  line read request; level, sampled only while ufp_ready=1.
ufp_write  input  1  line write request; level, sampled only while ufp_ready=1.
ufp_addr  input  ADDR_WIDTH  byte address; bits [4:0] are ignored and forced to 0.
ufp_wdata  input  BEATS*BUS_WIDTH  write line; beat i is bits [64i+63:64i].
ufp_ready  output  1  1 in IDLE only.
ufp_rdata  output  BEATS*BUS_WIDTH  read line; valid when ufp_resp=1, then held until the next read completes.
ufp_resp  output  1  single-cycle completion pulse.
address_data_bus_o  output  BUS_WIDTH  multiplexed address/data to the BRAM.
address_on_o  output  1  marks an address beat.
data_on_o  output  1  marks a write data beat.
read_en_o  output  1  read operation qualifier.
write_en_o  output  1  write operation qualifier.
address_data_bus_i  input  BUS_WIDTH  read data returned by the BRAM.
resp_i  input  1  BRAM response: one pulse per read beat, one pulse per write.
error_o  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All outputs 0 except ufp_ready=1.
  - ufp_rdata=0, error_o=0; beat and timeout counters cleared.
  - Reset mid-transaction aborts it; no ufp_resp is produced.
- All outputs are registered; bus outputs are 0 in any state that does not drive them.
- IDLE: if ufp_write or ufp_read is 1, latch the aligned address, ufp_wdata and the operation, then go to ADDR.
  - If both are 1, the write wins; the read is not queued.
- ADDR (1 cycle): address_on_o=1; read_en_o or write_en_o=1 per the operation; bus_o={zero-ext, addr[31:5],5'b0}.
  - Then go to WDATA (write) or RDATA (read).
- WDATA (BEATS cycles): data_on_o=1, write_en_o=1, bus_o=beat k, with k=0..3 ascending on consecutive cycles.
  - After beat 3, go to WRESP.
- WRESP: write_en_o=1; wait for resp_i, then go to DONE.
  - resp_i during ADDR or WDATA is ignored.
- RDATA: read_en_o=1; each cycle with resp_i=1 captures address_data_bus_i into beat k and increments k.
  - After the 4th beat, go to DONE. Beats may be non-consecutive.
- DONE (1 cycle): ufp_resp=1, then IDLE. ufp_rdata is updated only by reads.
- Timeout: the counter runs in WRESP/RDATA, clears on each resp_i, and restarts on entry.
  - When it reaches TIMEOUT_CYCLES: error_o<=1 (sticky until reset), then go to DONE.
  - On a timed-out read, uncaptured beats are 0 and captured beats are kept.
- resp_i in IDLE or DONE is ignored. Extra resp_i pulses after completion have no effect.
- Latency from the accept cycle T:
  - Write: ADDR at T+1, data at T+2..T+5, WRESP from T+6; resp_i at T+6 gives ufp_resp at T+7.
  - Read: back-to-back resp_i at T+2..T+5 gives ufp_resp at T+6.
- Throughput: one transaction in flight; the next is accepted in the cycle after DONE.

Test Plan:
- Write addr=0x0000_1234, wdata beats {0x11..,0x22..,0x33..,0x44..}, resp_i at T+6 -> bus_o=0x1220 with address_on_o=1 at T+1; beats in order with data_on_o=1 at T+2..T+5; ufp_resp=1 at T+7.
- Read addr=0x40, BRAM returns 0xA0,0xA1,0xA2,0xA3 at T+2..T+5 -> ufp_rdata={0xA3,0xA2,0xA1,0xA0} (beat 0 in LSBs), ufp_resp at T+6.
- Read with resp_i gaps (beats at T+2,T+5,T+6,T+10) -> correct line, ufp_resp at T+11, error_o=0.
- ufp_read=ufp_write=1 in IDLE -> write_en_o=1 transaction only; ufp_rdata unchanged.
- No resp_i after read ADDR -> error_o=1 after TIMEOUT_CYCLES idle cycles; ufp_resp pulses once; ufp_rdata=0; error_o stays 1 across later successful transactions.
- rst=0 asserted during WDATA beat 2 -> outputs 0 immediately, ufp_ready=1, no ufp_resp; a new write after release completes normally.

Source files
------------

// File: rtl/fpga_bram_ctrl.sv
// Serializes 256-bit cache-line reads/writes onto the BRAM's multiplexed 64-bit bus:
// one address beat followed by BEATS data beats, with a sticky response timeout.
module fpga_bram_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_WIDTH      = 64,
    parameter int BEATS          = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ufp_read,
    input  logic                       ufp_write,
    input  logic [ADDR_WIDTH-1:0]      ufp_addr,
    input  logic [BEATS*BUS_WIDTH-1:0] ufp_wdata,
    output logic                       ufp_ready,
    output logic [BEATS*BUS_WIDTH-1:0] ufp_rdata,
    output logic                       ufp_resp,
    output logic [BUS_WIDTH-1:0]       address_data_bus_o,
    output logic                       address_on_o,
    output logic                       data_on_o,
    output logic                       read_en_o,
    output logic                       write_en_o,
    input  logic [BUS_WIDTH-1:0]       address_data_bus_i,
    input  logic                       resp_i,
    output logic                       error_o
);

    localparam int LINE_W = BEATS * BUS_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA, DONE} state_t;

    state_t                  state, state_n;
    logic [BEAT_W-1:0]       beat, beat_n;
    logic [TMR_W-1:0]        timer, timer_n;
    logic                    op_write, op_n;
    logic [ADDR_WIDTH-6:0]   line_addr, line_addr_n;
    logic [LINE_W-1:0]       wdata_q, wdata_n;
    logic [LINE_W-1:0]       rbuf, rbuf_n;
    logic                    accept, timeout;

    logic                    ready_n, resp_n, addr_on_n, data_on_n, rd_en_n, wr_en_n;
    logic [BUS_WIDTH-1:0]    bus_n;

    // Byte offset within the line is discarded by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ufp_addr[4:0];

    always_comb begin
        state_n     = state;
        beat_n      = beat;
        timer_n     = timer;
        accept      = 1'b0;
        timeout     = 1'b0;
        op_n        = op_write;
        line_addr_n = line_addr;
        wdata_n     = wdata_q;
        rbuf_n      = rbuf;

        case (state)
            IDLE: begin
                beat_n  = '0;
                timer_n = '0;
                if (ufp_write || ufp_read) begin
                    accept      = 1'b1;
                    op_n        = ufp_write;
                    line_addr_n = ufp_addr[ADDR_WIDTH-1:5];
                    wdata_n     = ufp_wdata;
                    rbuf_n      = '0;
                    state_n     = ADDR;
                end
            end
            ADDR: begin
                beat_n  = '0;
                timer_n = '0;
                state_n = op_write ? WDATA : RDATA;
            end
            WDATA: begin
                if (beat == BEAT_W'(BEATS - 1)) begin
                    beat_n  = '0;
                    state_n = WRESP;
                end else begin
                    beat_n = beat + 1'b1;
                end
            end
            WRESP: begin
                if (resp_i) begin
                    state_n = DONE;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            RDATA: begin
                if (resp_i) begin
                    timer_n = '0;
                    rbuf_n[int'(beat)*BUS_WIDTH +: BUS_WIDTH] = address_data_bus_i;
                    if (beat == BEAT_W'(BEATS - 1)) begin
                        state_n = DONE;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DONE: begin
                timer_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the state they describe.
    always_comb begin
        ready_n   = (state_n == IDLE);
        resp_n    = (state_n == DONE);
        addr_on_n = (state_n == ADDR);
        data_on_n = (state_n == WDATA);
        wr_en_n   = op_n && (state_n == ADDR || state_n == WDATA || state_n == WRESP);
        rd_en_n   = !op_n && (state_n == ADDR || state_n == RDATA);
        bus_n     = '0;
        if (state_n == ADDR) begin
            bus_n = BUS_WIDTH'({line_addr_n, 5'b0});
        end else if (state_n == WDATA) begin
            bus_n = wdata_n[int'(beat_n)*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat      <= '0;
            timer     <= '0;
            op_write  <= 1'b0;
            line_addr <= '0;
            wdata_q   <= '0;
            rbuf      <= '0;
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            timer     <= timer_n;
            op_write  <= op_n;
            line_addr <= line_addr_n;
            wdata_q   <= wdata_n;
            rbuf      <= rbuf_n;
        end
    end

    // A timed-out read still publishes its partially captured (zero-filled) line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ufp_ready          <= 1'b1;
            ufp_resp           <= 1'b0;
            ufp_rdata          <= '0;
            address_data_bus_o <= '0;
            address_on_o       <= 1'b0;
            data_on_o          <= 1'b0;
            read_en_o          <= 1'b0;
            write_en_o         <= 1'b0;
            error_o            <= 1'b0;
        end else begin
            ufp_ready          <= ready_n;
            ufp_resp           <= resp_n;
            address_data_bus_o <= bus_n;
            address_on_o       <= addr_on_n;
            data_on_o          <= data_on_n;
            read_en_o          <= rd_en_n;
            write_en_o         <= wr_en_n;
            if (timeout) begin
                error_o <= 1'b1;
            end
            if (state == RDATA && state_n == DONE) begin
                ufp_rdata <= rbuf_n;
            end
        end
    end

endmodule

// File: tb/tb_fpga_bram_ctrl.sv
// Table-driven bench for fpga_bram_ctrl with a completion scoreboard and
// hand-written timeout / mid-transaction reset sequences.
module tb_fpga_bram_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         ufp_read, ufp_write;
    logic [31:0]  ufp_addr;
    logic [255:0] ufp_wdata;
    logic         ufp_ready;
    logic [255:0] ufp_rdata;
    logic         ufp_resp;
    logic [63:0]  address_data_bus_o;
    logic         address_on_o, data_on_o, read_en_o, write_en_o;
    logic [63:0]  address_data_bus_i;
    logic         resp_i;
    logic         error_o;

    fpga_bram_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .ufp_read           (ufp_read),
        .ufp_write          (ufp_write),
        .ufp_addr           (ufp_addr),
        .ufp_wdata          (ufp_wdata),
        .ufp_ready          (ufp_ready),
        .ufp_rdata          (ufp_rdata),
        .ufp_resp           (ufp_resp),
        .address_data_bus_o (address_data_bus_o),
        .address_on_o       (address_on_o),
        .data_on_o          (data_on_o),
        .read_en_o          (read_en_o),
        .write_en_o         (write_en_o),
        .address_data_bus_i (address_data_bus_i),
        .resp_i             (resp_i),
        .error_o            (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic         rd;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rline;
        logic [15:0]  mask;
        int           done;
        logic [63:0]  exp_bus;
    } vec_t;

    typedef struct {
        logic [255:0] line;
        logic         err;
        int           lo;
        int           hi;
    } sb_t;

    vec_t         vecs [5];
    vec_t         tvec;
    sb_t          sb [$];
    int           total  = 0;
    int           passed = 0;
    int           cyc    = 0;
    logic [255:0] last_rdata = '0;
    logic         exp_err    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    // Every completion pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && ufp_resp === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("unexpected_resp", ufp_resp, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check_output("resp_cycle_in_window", (cyc >= e.lo && cyc <= e.hi), 1);
                check_output("rdata", ufp_rdata, e.line);
                check_output("error_at_done", error_o, e.err);
            end
        end
    end

    task automatic apply_stimulus(input vec_t v, input int lo, input int hi);
        int j;
        int t0;
        j  = 0;
        t0 = 0;
        for (int c = 0; c <= hi + 1; c++) begin
            @(posedge clk); #1;
            ufp_write = (c == 0) ? v.wr : 1'b0;
            ufp_read  = (c == 0) ? v.rd : 1'b0;
            ufp_addr  = v.addr;
            ufp_wdata = v.wdata;
            resp_i    = (c < 16) ? v.mask[c] : 1'b0;
            address_data_bus_i = {32'hDEADBEEF, 32'(c)};
            if (resp_i && !v.wr && j < 4) begin
                address_data_bus_i = v.rline[j*64 +: 64];
                j++;
            end
            if (c == 0) begin
                t0 = cyc;
                sb.push_back('{line: (v.wr ? last_rdata : v.rline), err: exp_err, lo: t0 + lo, hi: t0 + hi});
                if (!v.wr) last_rdata = v.rline;
            end
            @(negedge clk);
            if (c == 0) check_output("ready_idle", ufp_ready, 1);
            if (c == 1) begin
                check_output("addr_on", address_on_o, 1);
                check_output("addr_bus", address_data_bus_o, v.exp_bus);
                check_output("addr_wr_en", write_en_o, v.wr);
                check_output("addr_rd_en", read_en_o, !v.wr);
                check_output("addr_ready", ufp_ready, 0);
            end
            if (v.wr && c >= 2 && c <= 5) begin
                check_output("wdata_on", data_on_o, 1);
                check_output("wdata_wr_en", write_en_o, 1);
                check_output("wdata_bus", address_data_bus_o, v.wdata[(c-2)*64 +: 64]);
            end
            if (v.wr && c >= 6 && c < lo) begin
                check_output("wresp_wr_en", write_en_o, 1);
                check_output("wresp_bus", {data_on_o, address_data_bus_o}, 0);
            end
            if (!v.wr && c >= 2 && c < lo) begin
                check_output("rdata_rd_en", read_en_o, 1);
                check_output("rdata_bus", {write_en_o, data_on_o, address_data_bus_o}, 0);
            end
            if (c == hi + 1) begin
                check_output("back_idle_ready", ufp_ready, 1);
                check_output("back_idle_resp", ufp_resp, 0);
            end
        end
        resp_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_1234,
                    wdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    rline: '0, mask: 16'h0048, done: 7, exp_bus: 64'h1220};
        vecs[1] = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_0040, wdata: '0,
                    rline: {64'hA3, 64'hA2, 64'hA1, 64'hA0},
                    mask: 16'h00BC, done: 6, exp_bus: 64'h40};
        vecs[2] = '{wr: 1'b0, rd: 1'b1, addr: 32'hFFFF_FFFF, wdata: '0,
                    rline: {64'hFEDC_BA98_7654_3210, 64'h0F0F_F0F0_5A5A_A5A5,
                            64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF},
                    mask: 16'h0464, done: 11, exp_bus: 64'h0000_0000_FFFF_FFE0};
        vecs[3] = '{wr: 1'b1, rd: 1'b1, addr: 32'h0000_0080,
                    wdata: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    rline: '0, mask: 16'h0140, done: 7, exp_bus: 64'h80};
        vecs[4] = '{wr: 1'b1, rd: 1'b0, addr: 32'h8000_001F,
                    wdata: {64'h0BAD_F00D_0000_0004, 64'h0BAD_F00D_0000_0003,
                            64'h0BAD_F00D_0000_0002, 64'h0BAD_F00D_0000_0001},
                    rline: '0, mask: 16'h0200, done: 10, exp_bus: 64'h8000_0000};
        tvec    = '{wr: 1'b0, rd: 1'b1, addr: 32'h0000_0200, wdata: '0,
                    rline: '0, mask: 16'h0000, done: 1025, exp_bus: 64'h200};

        rst = 1'b0;
        ufp_read = 1'b0; ufp_write = 1'b0; ufp_addr = '0; ufp_wdata = '0;
        address_data_bus_i = '0; resp_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_ready", ufp_ready, 1);
        check_output("reset_outputs", {ufp_resp, address_on_o, data_on_o, read_en_o, write_en_o, error_o}, 0);
        check_output("reset_bus", address_data_bus_o, 0);
        check_output("reset_rdata", ufp_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], vecs[i].done, vecs[i].done);

        exp_err = 1'b1;
        apply_stimulus(tvec, 1024, 1026);
        check_output("error_sticky_after_timeout", error_o, 1);
        apply_stimulus(vecs[1], vecs[1].done, vecs[1].done);
        check_output("error_sticky_after_read", error_o, 1);

        // Abort a write while beat 2 is on the bus.
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk); #1;
            ufp_write = (c == 0);
            ufp_addr  = 32'h0000_0300;
            ufp_wdata = vecs[4].wdata;
            resp_i    = 1'b0;
            if (c == 3) begin
                @(negedge clk);
                check_output("pre_reset_beat1", address_data_bus_o, vecs[4].wdata[64 +: 64]);
            end
        end
        check_output("pre_reset_beat2", address_data_bus_o, vecs[4].wdata[128 +: 64]);
        rst = 1'b0;
        #1;
        check_output("async_reset_ready", ufp_ready, 1);
        check_output("async_reset_outputs", {ufp_resp, address_on_o, data_on_o, read_en_o, write_en_o, error_o}, 0);
        check_output("async_reset_bus", address_data_bus_o, 0);
        check_output("async_reset_rdata", ufp_rdata, 0);
        last_rdata = '0;
        exp_err    = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("post_reset_no_resp", ufp_resp, 0);

        apply_stimulus(vecs[0], vecs[0].done, vecs[0].done);

        repeat (2) @(posedge clk);
        check_output("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
